colour_fader: RTL and testbench
===============================

// Module: colour_fader
// PURPOSE
//  Downstream stage of the dynamic-lighting block. Consumes its 3-bit colour code (legal 1..6)
//  and drives three PWM LED outputs (R,G,B) at a programmable brightness.
//  On every colour or brightness change, each channel ramps linearly to its new duty.
//  Illegal codes (000/111) are rejected and flagged.
// PARAMETERS
//  PWM_WIDTH    8  PWM counter/duty width; PWM period = 2**PWM_WIDTH cycles
//  STEP_CYCLES  4  clock cycles between fade steps (>=1); each step moves a duty by 1
// PORTS
//  clk         in   1          system clock, all logic on rising edge
//  rst         in   1          synchronous, active-high reset
//  enable      in   1          1 = run; 0 = outputs dark, fade frozen
//  colour      in   3          colour code from upstream: [2]=R, [1]=G, [0]=B
//  brightness  in   PWM_WIDTH  target duty for every channel whose colour bit is 1
//  rgb         out  3          registered PWM outputs: [2]=R, [1]=G, [0]=B
//  busy        out  1          1 while any channel duty != its target
//  illegal     out  1          one-cycle pulse when colour==000 or 111 is sampled
// BEHAVIOUR
//  Reset (rst=1 at edge): pwm_cnt=0, duty_r/g/b=0, latched colour=000, latched brightness=0,
//   step_cnt=0, FSM=IDLE, rgb=000, busy=0, illegal=0. Reset wins over every other input.
//  pwm_cnt: free-running 0..2**PWM_WIDTH-1, wraps to 0. Runs whenever rst=0, including when enable=0.
//  rgb[i] <= enable & (pwm_cnt < duty_i), registered, so 1 cycle latency from duty/pwm_cnt.
//   duty 0 -> always 0; duty max -> high 2**PW-1 of every 2**PW cycles.
//  Target: tgt_i = latched_colour[i] ? latched_brightness : 0.
//  Sampling (each edge, enable=1):
//   - colour legal and (colour != latched colour or brightness != latched): latch both; FSM->FADE.
//   - colour illegal: illegal<=1 for that edge only; latched colour unchanged.
//     A brightness change is still latched.
//  FSM IDLE: busy=0, step_cnt held 0. Moves to FADE on retarget; busy=1 from that same edge.
//  FSM FADE: step_cnt counts 0..STEP_CYCLES-1.
//   At the edge where step_cnt==STEP_CYCLES-1, every duty_i != tgt_i moves 1 toward tgt_i,
//   and step_cnt wraps to 0.
//   The first step occurs STEP_CYCLES edges after the retarget edge.
//   If all duties equal their targets after a step, FSM->IDLE and busy<=0 on that same edge.
//  Channels fade concurrently and independently (one rises while another falls).
//   Fade length = max|tgt_i - duty_i| * STEP_CYCLES cycles.
//  Retarget mid-fade: new target latched; duties continue from current values; step_cnt NOT reset.
//  Retarget to current duties (e.g. A->B->A before any step): FSM returns to IDLE on the next edge.
//  enable=0: sampling, step_cnt, duties and FSM frozen; rgb<=000 on the next edge.
//   busy and illegal hold 0/last busy; illegal=0. On re-enable, operation resumes from the frozen state.
//  Duty arithmetic saturates: never steps below 0 or above tgt; no wrap.
// CONFIGURATION
//  GAMMA_EN defined: compare value = (duty_i*duty_i) >> PWM_WIDTH (2*PW-bit product, upper
//   PW bits), giving perceptual square-law brightness; duty==max maps to max-1 compare.
//   All fade timing is unchanged.
//  GAMMA_EN undefined: compare value = duty_i directly (linear). No product logic synthesised.
// TESTING  (PWM_WIDTH=4, STEP_CYCLES=2, brightness=15, enable=1 unless stated; linear build)
//  1 rst=1 for 5 cycles -> rgb=000, busy=0, illegal=0 throughout.
//    Release with colour=001 -> busy=1 after first edge; B duty reaches 15 after 30 cycles; busy->0.
//  2 Steady colour=001 -> over any 16-cycle window rgb[0] high exactly 15 cycles, rgb[2:1]=0.
//  3 colour 001->010 -> B falls and G rises together; after 30 cycles G high 15/16, B 0/16, busy->0.
//  4 Steady colour=100, brightness 15->8 -> R fades down over 14 cycles to 8/16 high; G,B stay 0.
//  5 colour=111 for 1 cycle mid-steady -> illegal=1 one cycle, rgb pattern and busy unchanged;
//    colour=000 same.
//  6 enable=0 mid-fade for 10 cycles -> rgb=000, duties frozen; re-enable completes remaining steps.
//    rst=1 mid-fade -> rgb=000, busy=0 on next edge.

Source files
------------

// File: rtl/colour_fader.sv
// Three-channel PWM LED driver that ramps each channel linearly toward its colour/brightness target.
// Define GAMMA_EN for square-law PWM compare values; leave it undefined for a linear compare.
module colour_fader #(
  parameter int PWM_WIDTH   = 8,
  parameter int STEP_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [2:0]           colour,
  input  logic [PWM_WIDTH-1:0] brightness,
  output logic [2:0]           rgb,
  output logic                 busy,
  output logic                 illegal
);

  localparam int SW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYCLES - 1);

  typedef enum logic {IDLE, FADE} state_t;

  state_t               state_reg, state_next;
  logic [SW-1:0]        step_cnt_reg, step_cnt_next;
  logic [PWM_WIDTH-1:0] pwm_cnt_reg;
  logic [PWM_WIDTH-1:0] duty_reg  [3];
  logic [PWM_WIDTH-1:0] duty_next [3];
  logic [PWM_WIDTH-1:0] tgt       [3];
  logic [PWM_WIDTH-1:0] cmp       [3];
  logic [2:0]           match;
  logic [2:0]           colour_reg;
  logic [PWM_WIDTH-1:0] bright_reg;
  logic [2:0]           rgb_reg;
  logic                 illegal_reg;
  logic                 colour_legal;
  logic                 retarget;
  logic                 step_edge;
  logic                 settled;

  assign colour_legal = (colour != 3'b000) && (colour != 3'b111);

  // An illegal code never changes the latched colour, but a new brightness still retargets.
  assign retarget = enable &&
                    (colour_legal ? ((colour != colour_reg) || (brightness != bright_reg))
                                  : (brightness != bright_reg));

  assign step_edge = enable && (state_reg == FADE) && (step_cnt_reg == STEP_LAST);

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_chan
      assign tgt[gi] = colour_reg[gi] ? bright_reg : '0;

      always_comb begin
        duty_next[gi] = duty_reg[gi];
        if (step_edge) begin
          if (duty_reg[gi] < tgt[gi])
            duty_next[gi] = duty_reg[gi] + PWM_WIDTH'(1);
          else if (duty_reg[gi] > tgt[gi])
            duty_next[gi] = duty_reg[gi] - PWM_WIDTH'(1);
        end
      end

      assign match[gi] = (duty_next[gi] == tgt[gi]);

`ifdef GAMMA_EN
      logic [2*PWM_WIDTH-1:0] sq;
      assign sq      = {{PWM_WIDTH{1'b0}}, duty_reg[gi]} * {{PWM_WIDTH{1'b0}}, duty_reg[gi]};
      assign cmp[gi] = sq[2*PWM_WIDTH-1:PWM_WIDTH];
`else
      assign cmp[gi] = duty_reg[gi];
`endif
    end
  endgenerate

  assign settled = &match;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      step_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      step_cnt_reg <= step_cnt_next;
    end
  end

  // FSM: next state; a retarget back onto the current duties drops to IDLE on the following edge
  always_comb begin
    state_next    = state_reg;
    step_cnt_next = step_cnt_reg;
    if (enable) begin
      case (state_reg)
        IDLE: begin
          step_cnt_next = '0;
          if (retarget)
            state_next = FADE;
        end
        FADE: begin
          step_cnt_next = step_edge ? '0 : step_cnt_reg + SW'(1);
          if (!retarget && settled) begin
            state_next    = IDLE;
            step_cnt_next = '0;
          end
        end
        default: begin
          state_next    = IDLE;
          step_cnt_next = '0;
        end
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    busy    = (state_reg == FADE);
    rgb     = rgb_reg;
    illegal = illegal_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt_reg <= '0;
      colour_reg  <= 3'b000;
      bright_reg  <= '0;
      rgb_reg     <= 3'b000;
      illegal_reg <= 1'b0;
      for (int i = 0; i < 3; i++)
        duty_reg[i] <= '0;
    end else begin
      pwm_cnt_reg <= pwm_cnt_reg + PWM_WIDTH'(1);
      illegal_reg <= enable && !colour_legal;
      for (int i = 0; i < 3; i++)
        rgb_reg[i] <= enable && (pwm_cnt_reg < cmp[i]);
      if (enable) begin
        if (retarget) begin
          if (colour_legal)
            colour_reg <= colour;
          bright_reg <= brightness;
        end
        for (int i = 0; i < 3; i++)
          duty_reg[i] <= duty_next[i];
      end
    end
  end

endmodule

// File: tb/tb_colour_fader.sv
// Directed bench for colour_fader at PWM_WIDTH=4, STEP_CYCLES=2 (linear build).
module tb_colour_fader;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [2:0] colour;
  logic [3:0] brightness;
  logic [2:0] rgb;
  logic       busy;
  logic       illegal;

  int total = 0;
  int bad   = 0;

  colour_fader #(.PWM_WIDTH(4), .STEP_CYCLES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .colour     (colour),
    .brightness (brightness),
    .rgb        (rgb),
    .busy       (busy),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  // Counts negedges with busy high until busy drops; timeout set if it never does.
  task automatic wait_busy_low(output int cnt, output bit timeout);
    cnt = 0;
    timeout = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) begin
        timeout = 1'b0;
        break;
      end
      cnt++;
    end
  endtask

  // One settling cycle for the registered output, then a full 16-cycle PWM window.
  task automatic measure(output int r, output int g, output int b);
    r = 0; g = 0; b = 0;
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      r += int'(rgb[2]);
      g += int'(rgb[1]);
      b += int'(rgb[0]);
    end
  endtask

  task automatic test_reset;
    int cnt;
    bit to;
    rst = 1'b1; enable = 1'b1; colour = 3'b001; brightness = 4'd15;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (rgb !== 3'b000) begin bad++; $display("FAIL reset_rgb: got %b want 000", rgb); end
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      total++;
      if (illegal !== 1'b0) begin bad++; $display("FAIL reset_illegal: got %b want 0", illegal); end
    end
    rst = 1'b0;
    wait_busy_low(cnt, to);
    total++;
    if (to || cnt !== 30) begin
      bad++; $display("FAIL fade_up_busy_cycles: got %0d (timeout=%0d) want 30", cnt, to);
    end
    $display("reset + fade-up 001: busy cycles %0d", cnt);
  endtask

  task automatic test_steady;
    int r, g, b;
    measure(r, g, b);
    total++;
    if (b !== 15) begin bad++; $display("FAIL steady_b_high: got %0d want 15", b); end
    total++;
    if (r !== 0 || g !== 0) begin bad++; $display("FAIL steady_rg_dark: got r=%0d g=%0d want 0 0", r, g); end
    $display("steady 001: r=%0d g=%0d b=%0d", r, g, b);
  endtask

  task automatic test_crossfade;
    int cnt, r, g, b;
    bit to;
    colour = 3'b010;
    wait_busy_low(cnt, to);
    total++;
    if (to || cnt !== 30) begin
      bad++; $display("FAIL crossfade_busy_cycles: got %0d (timeout=%0d) want 30", cnt, to);
    end
    measure(r, g, b);
    total++;
    if (g !== 15 || b !== 0 || r !== 0) begin
      bad++; $display("FAIL crossfade_pwm: got r=%0d g=%0d b=%0d want 0 15 0", r, g, b);
    end
    $display("crossfade 001->010: busy %0d, r=%0d g=%0d b=%0d", cnt, r, g, b);
  endtask

  task automatic test_brightness_down;
    int cnt, r, g, b;
    bit to;
    colour = 3'b100;
    wait_busy_low(cnt, to);
    total++;
    if (to || cnt !== 30) begin
      bad++; $display("FAIL to_red_busy_cycles: got %0d (timeout=%0d) want 30", cnt, to);
    end
    brightness = 4'd8;
    wait_busy_low(cnt, to);
    total++;
    if (to || cnt !== 14) begin
      bad++; $display("FAIL dim_busy_cycles: got %0d (timeout=%0d) want 14", cnt, to);
    end
    measure(r, g, b);
    total++;
    if (r !== 8 || g !== 0 || b !== 0) begin
      bad++; $display("FAIL dim_pwm: got r=%0d g=%0d b=%0d want 8 0 0", r, g, b);
    end
    $display("dim 100 15->8: busy %0d, r=%0d g=%0d b=%0d", cnt, r, g, b);
  endtask

  task automatic test_illegal;
    logic [2:0] codes [2];
    int r, busy_hits;
    codes[0] = 3'b111;
    codes[1] = 3'b000;
    for (int c = 0; c < 2; c++) begin
      r = 0; busy_hits = 0;
      for (int i = 0; i < 16; i++) begin
        if (i == 0) colour = codes[c];
        @(negedge clk);
        r += int'(rgb[2]);
        busy_hits += int'(busy);
        if (i == 0) begin
          total++;
          if (illegal !== 1'b1) begin bad++; $display("FAIL illegal_pulse: code %b got %b want 1", codes[c], illegal); end
          colour = 3'b100;
        end
        if (i == 1) begin
          total++;
          if (illegal !== 1'b0) begin bad++; $display("FAIL illegal_one_cycle: code %b got %b want 0", codes[c], illegal); end
        end
      end
      total++;
      if (r !== 8 || busy_hits !== 0) begin
        bad++; $display("FAIL illegal_no_effect: code %b got r=%0d busy=%0d want 8 0", codes[c], r, busy_hits);
      end
      $display("illegal code %b: r=%0d busy=%0d", codes[c], r, busy_hits);
    end
  endtask

  task automatic test_enable_freeze;
    int cnt, early, r, g, b;
    bit to;
    colour = 3'b001; brightness = 4'd15;
    early = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      early += int'(busy);
    end
    total++;
    if (early !== 10) begin bad++; $display("FAIL freeze_pre_busy: got %0d want 10", early); end
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if (rgb !== 3'b000 || busy !== 1'b1 || illegal !== 1'b0) begin
        bad++; $display("FAIL frozen_outputs: got rgb=%b busy=%b illegal=%b want 000 1 0", rgb, busy, illegal);
      end
    end
    enable = 1'b1;
    wait_busy_low(cnt, to);
    total++;
    if (to || cnt !== 20) begin
      bad++; $display("FAIL resume_busy_cycles: got %0d (timeout=%0d) want 20", cnt, to);
    end
    measure(r, g, b);
    total++;
    if (r !== 0 || g !== 0 || b !== 15) begin
      bad++; $display("FAIL resume_pwm: got r=%0d g=%0d b=%0d want 0 0 15", r, g, b);
    end
    $display("freeze mid-fade: remaining busy %0d, r=%0d g=%0d b=%0d", cnt, r, g, b);
  endtask

  task automatic test_reset_mid_fade;
    int cnt, r, g, b;
    bit to;
    colour = 3'b100;
    repeat (5) @(negedge clk);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL midfade_busy: got %b want 1", busy); end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (rgb !== 3'b000 || busy !== 1'b0 || illegal !== 1'b0) begin
      bad++; $display("FAIL midfade_reset: got rgb=%b busy=%b illegal=%b want 000 0 0", rgb, busy, illegal);
    end
    @(negedge clk);
    rst = 1'b0;
    wait_busy_low(cnt, to);
    total++;
    if (to || cnt !== 30) begin
      bad++; $display("FAIL post_reset_busy_cycles: got %0d (timeout=%0d) want 30", cnt, to);
    end
    measure(r, g, b);
    total++;
    if (r !== 15 || g !== 0 || b !== 0) begin
      bad++; $display("FAIL post_reset_pwm: got r=%0d g=%0d b=%0d want 15 0 0", r, g, b);
    end
    $display("reset mid-fade: busy %0d, r=%0d g=%0d b=%0d", cnt, r, g, b);
  endtask

  task automatic test_back_to_back;
    int cnt, first, r, g, b;
    bit to;
    colour = 3'b010;
    @(negedge clk);
    first = int'(busy);
    colour = 3'b100;
    wait_busy_low(cnt, to);
    total++;
    if (to || first + cnt !== 2) begin
      bad++; $display("FAIL bounce_busy_cycles: got %0d (timeout=%0d) want 2", first + cnt, to);
    end
    measure(r, g, b);
    total++;
    if (r !== 15 || g !== 0 || b !== 0) begin
      bad++; $display("FAIL bounce_pwm: got r=%0d g=%0d b=%0d want 15 0 0", r, g, b);
    end
    $display("bounce 100->010->100: busy %0d, r=%0d g=%0d b=%0d", first + cnt, r, g, b);
  endtask

  initial begin
    test_reset;
    test_steady;
    test_crossfade;
    test_brightness_down;
    test_illegal;
    test_enable_freeze;
    test_reset_mid_fade;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
